// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the core memory-port arbiter: data-path widths,
// requester identifiers and a small one-hot helper.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int unsigned Xlen     = 32;
    localparam int unsigned MaskBits = Xlen / 8;
    localparam int unsigned NumPorts = 2;

    typedef logic mem_port_id_t;

    localparam mem_port_id_t PortFetch = 1'b0;
    localparam mem_port_id_t PortLsu   = 1'b1;

    // One-hot strobe for a requester ID.
    function automatic logic [NumPorts-1:0] port_onehot(input mem_port_id_t id);
        return (id == PortLsu) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester-side and memory-side signals of the arbiter.
//   Requester side : req_valid_i, req_ready_o, req_addr_i, req_wdata_i,
//                    req_wmask_i, rsp_rdata_o, rsp_valid_o (indexed 0=fetch,
//                    1=LSU)
//   Memory side    : mem_valid_o, mem_ready_i, mem_addr_o, mem_wdata_o,
//                    mem_wmask_o, mem_rdata_i, mem_rvalid_i
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters + memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [NumPorts-1:0]                req_valid_i;
    logic [NumPorts-1:0]                req_ready_o;
    logic [NumPorts-1:0][Xlen-1:0]      req_addr_i;
    logic [NumPorts-1:0][Xlen-1:0]      req_wdata_i;
    logic [NumPorts-1:0][MaskBits-1:0]  req_wmask_i;
    logic [Xlen-1:0]                    rsp_rdata_o;
    logic [NumPorts-1:0]                rsp_valid_o;

    logic                               mem_valid_o;
    logic                               mem_ready_i;
    logic [Xlen-1:0]                    mem_addr_o;
    logic [Xlen-1:0]                    mem_wdata_o;
    logic [MaskBits-1:0]                mem_wmask_o;
    logic [Xlen-1:0]                    mem_rdata_i;
    logic                               mem_rvalid_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_wmask_i,
        input  mem_ready_i, mem_rdata_i, mem_rvalid_i,
        output req_ready_o, rsp_rdata_o, rsp_valid_o,
        output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_wmask_i,
        output mem_ready_i, mem_rdata_i, mem_rvalid_i,
        input  req_ready_o, rsp_rdata_o, rsp_valid_o,
        input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );

endinterface

// File: rtl/mem_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// id_fifo
// Synchronous FIFO with asynchronous active-high reset.
// Pointers carry one extra wrap bit so full/empty come straight from the
// registered pointer difference.
//   clk_i, rst_i : clock / async reset
//   push_i       : write data_i (ignored when full)
//   pop_i        : drop head entry (ignored when empty)
//   data_i       : entry to write
//   head_o       : oldest entry
//   full_o       : Depth entries held
//   empty_o      : no entries held
// -----------------------------------------------------------------------------
module id_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = (AW == 0) ? 1 : AW;

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    // Depth==1 has no index bits; every access hits entry 0.
    assign wr_idx = (AW == 0) ? '0 : wr_ptr_q[IW-1:0];
    assign rd_idx = (AW == 0) ? '0 : rd_ptr_q[IW-1:0];

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count == PW'(Depth));
    assign empty_o = (count == '0);
    assign head_o  = mem_q[rd_idx];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed while non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single core memory port between instruction fetch (port 0) and
// the load/store unit (port 1). Round-robin selection, grant locked while the
// memory stalls a presented request, in-order tracking of outstanding
// transactions so each response strobes the requester that issued it.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : requester + memory signals (mem_arbiter_if.slave)
//   err_o  : sticky, set by a memory response while nothing is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus,
    output logic          err_o
);

    mem_port_id_t rr_q, rr_d;
    mem_port_id_t lock_id_q, lock_id_d;
    logic         lock_q, lock_d;
    logic         err_q, err_d;

    mem_port_id_t winner, grant, sel, fifo_head;
    logic         fifo_full, fifo_empty;
    logic         mem_valid, handshake, rsp_accept;

    // Unlocked selection: a lone requester wins, a tie goes to rr_q.
    always_comb begin
        winner = PortFetch;
        if (bus.req_valid_i[PortFetch] && bus.req_valid_i[PortLsu]) begin
            winner = rr_q;
        end else if (bus.req_valid_i[PortLsu]) begin
            winner = PortLsu;
        end
    end

    assign grant     = lock_q ? lock_id_q : winner;
    // fifo_full comes from registered pointers, so a same-cycle pop never
    // opens a slot for a same-cycle grant.
    assign mem_valid = bus.req_valid_i[grant] && !fifo_full;
    assign handshake = mem_valid && bus.mem_ready_i;

    // Idle payload is taken from port 0.
    assign sel = mem_valid ? grant : PortFetch;

    assign bus.mem_valid_o = mem_valid;
    assign bus.mem_addr_o  = bus.req_addr_i[sel];
    assign bus.mem_wdata_o = bus.req_wdata_i[sel];
    assign bus.mem_wmask_o = bus.req_wmask_i[sel];
    assign bus.req_ready_o = handshake ? port_onehot(grant) : '0;

    // Responses with nothing outstanding are dropped and flagged.
    assign rsp_accept      = bus.mem_rvalid_i && !fifo_empty;
    assign bus.rsp_valid_o = rsp_accept ? port_onehot(fifo_head) : '0;
    assign bus.rsp_rdata_o = bus.mem_rdata_i;
    assign err_o           = err_q;

    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q | (bus.mem_rvalid_i & fifo_empty);
        if (handshake) begin
            rr_d   = ~grant;
            lock_d = 1'b0;
        end else if (mem_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q      <= PortLsu;
            lock_q    <= 1'b0;
            lock_id_q <= PortFetch;
            err_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    id_fifo #(
        .Width (1),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .pop_i   (rsp_accept),
        .data_i  (grant),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
